// File: rtl/frame_pkg.sv
// Shared GFAS framing constants and transmit FSM state type.
package frame_pkg;

    localparam int unsigned ETH_HDR_LEN  = 14;
    localparam int unsigned GFAS_HDR_LEN = 6;
    localparam logic [47:0] GFAS_MAGIC   = 48'hFAF3_DEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        GFAS,
        PAYLOAD,
        GAP
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester strictly after ptr, circular.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    int unsigned idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = |req;
        idx         = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + N - i) % N;
            if (req[W'(idx)]) begin
                grant_idx = W'(idx);
            end
        end
    end

endmodule

// File: rtl/frame_tx_sched.sv
// Arbitrates register-file requesters and streams one GFAS frame per grant
// into the MAC tx FIFO.
module frame_tx_sched
    import frame_pkg::*;
#(
    parameter int unsigned Nsrc       = 4,
    parameter int unsigned Nregs      = 16,
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
    parameter logic [15:0] ETH_TYPE   = 16'h88B5,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               en,
    input  logic [Nsrc-1:0]                    req,
    input  logic [Nsrc-1:0][Nregs-1:0][31:0]   src_val,
    output logic [Nsrc-1:0]                    done,
    output logic                               busy,
    output logic [15:0]                        frame_cnt,
    output logic                               tx_fifo_tvalid,
    input  logic                               tx_fifo_tready,
    output logic [7:0]                         tx_fifo_tdata,
    output logic                               tx_fifo_tlast
);

    localparam int unsigned PTR_W    = (Nsrc > 1) ? $clog2(Nsrc) : 1;
    localparam int unsigned REG_W    = (Nregs > 1) ? $clog2(Nregs) : 1;
    localparam int unsigned HDR_LEN  = ETH_HDR_LEN + GFAS_HDR_LEN;
    localparam int unsigned LAST_IDX = HDR_LEN + Nregs * 4 - 1;
    localparam int unsigned CNT_W    = $clog2(LAST_IDX + 1);
    localparam int unsigned GAP_W    = $clog2(IFG_CYCLES + 1);
    localparam logic [HDR_LEN*8-1:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETH_TYPE, GFAS_MAGIC};

    tx_state_t                  state;
    logic [PTR_W-1:0]           ptr;
    logic [CNT_W-1:0]           cnt;
    logic [GAP_W-1:0]           gap;
    logic [Nregs-1:0][31:0]     shadow;
    logic [PTR_W-1:0]           grant_idx_c;
    logic                       grant_valid_c;
    logic [CNT_W-1:0]           nxt_cnt_c;

    rr_arbiter #(.N(Nsrc)) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant_idx   (grant_idx_c),
        .grant_valid (grant_valid_c)
    );

    assign nxt_cnt_c = cnt + CNT_W'(1);

    // Byte at frame offset idx: fixed header bytes, then registers MSB first.
    function automatic logic [7:0] frame_byte(input logic [CNT_W-1:0] idx,
                                              input logic [Nregs-1:0][31:0] regs);
        int unsigned i, r, b;
        i = 32'(idx);
        if (i < HDR_LEN) begin
            return 8'(HDR_BYTES >> (8 * (HDR_LEN - 1 - i)));
        end
        r = (i - HDR_LEN) / 4;
        b = (i - HDR_LEN) % 4;
        if (r >= Nregs) begin
            r = Nregs - 1;
        end
        return 8'(regs[REG_W'(r)] >> (8 * (3 - b)));
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            ptr            <= PTR_W'(Nsrc - 1);
            cnt            <= '0;
            gap            <= '0;
            shadow         <= '0;
            done           <= '0;
            busy           <= 1'b0;
            frame_cnt      <= '0;
            tx_fifo_tvalid <= 1'b0;
            tx_fifo_tdata  <= '0;
            tx_fifo_tlast  <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (en && grant_valid_c) begin
                        shadow         <= src_val[grant_idx_c];
                        ptr            <= grant_idx_c;
                        cnt            <= '0;
                        state          <= HDR;
                        busy           <= 1'b1;
                        tx_fifo_tvalid <= 1'b1;
                        tx_fifo_tdata  <= frame_byte(CNT_W'(0), src_val[grant_idx_c]);
                        tx_fifo_tlast  <= 1'b0;
                    end
                end
                HDR, GFAS, PAYLOAD: begin
                    // Everything holds while the FIFO back-pressures.
                    if (tx_fifo_tvalid && tx_fifo_tready) begin
                        if (tx_fifo_tlast) begin
                            tx_fifo_tvalid <= 1'b0;
                            tx_fifo_tlast  <= 1'b0;
                            done[ptr]      <= 1'b1;
                            frame_cnt      <= frame_cnt + 16'd1;
                            gap            <= GAP_W'(IFG_CYCLES);
                            state          <= GAP;
                        end else begin
                            cnt           <= nxt_cnt_c;
                            tx_fifo_tdata <= frame_byte(nxt_cnt_c, shadow);
                            tx_fifo_tlast <= (nxt_cnt_c == CNT_W'(LAST_IDX));
                            if (nxt_cnt_c < CNT_W'(ETH_HDR_LEN)) begin
                                state <= HDR;
                            end else if (nxt_cnt_c < CNT_W'(HDR_LEN)) begin
                                state <= GFAS;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap == GAP_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    gap <= gap - GAP_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
